// File: rtl/adder_tree_stream.sv
// Streaming NUM-lane reduction adder: registered lane capture, a registered binary
// adder tree, then an accumulator/output stage with optional packet accumulation.
module adder_tree_stream #(
  parameter int BITS     = 16,
  parameter int NUM      = 4,
  parameter int SIGNED   = 0,
  parameter int ACCUM    = 1,
  parameter int SATURATE = 0,
  parameter int OUT_BITS = 24
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NUM*BITS-1:0]   in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_BITS-1:0]   out_data,
  output logic                  out_overflow,
  output logic [7:0]            out_count
);

  localparam int LEVELS   = $clog2(NUM);
  localparam int SUM_BITS = BITS + LEVELS;

  function automatic logic [SUM_BITS-1:0] extend_lane(input logic [BITS-1:0] lane);
    logic sign;
    sign = (SIGNED != 0) && lane[BITS-1];
    return {{LEVELS{sign}}, lane};
  endfunction

  // node_q[0] holds the captured lanes; node_q[l] is the output of tree level l.
  logic [SUM_BITS-1:0] node_q [LEVELS+1][NUM];
  logic [SUM_BITS-1:0] src    [LEVELS][2*NUM];
  logic [LEVELS:0]     vld_q, lst_q;

  logic                en, in_fire;
  logic                out_valid_q, out_valid_d;
  logic [OUT_BITS-1:0] out_data_q, out_data_d;
  logic                out_ovf_q, out_ovf_d;
  logic [7:0]          out_count_q, out_count_d;
  logic [OUT_BITS-1:0] acc_q, acc_d;
  logic                ovf_sticky_q, ovf_sticky_d;
  logic [7:0]          cnt_q, cnt_d;

  assign en       = !(out_valid_q && !out_ready);
  assign in_ready = en && !resetn;
  assign in_fire  = in_valid && in_ready;

  // Zero padding above NUM turns an odd operand's "add" into a pass-through.
  always_comb begin
    for (int l = 0; l < LEVELS; l++) begin
      for (int k = 0; k < NUM; k++)       src[l][k] = node_q[l][k];
      for (int k = NUM; k < 2*NUM; k++)   src[l][k] = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every stage samples
  // the previous stage's pre-edge value, regardless of statement order.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      node_q <= '{default: '0};
      vld_q  <= '0;
      lst_q  <= '0;
    end else if (en) begin
      for (int j = 0; j < NUM; j++)
        node_q[0][j] <= extend_lane(in_data[j*BITS +: BITS]);
      for (int l = 0; l < LEVELS; l++)
        for (int j = 0; j < NUM; j++)
          node_q[l+1][j] <= src[l][2*j] + src[l][2*j+1];
      vld_q <= {vld_q[LEVELS-1:0], in_fire};
      lst_q <= {lst_q[LEVELS-1:0], in_last};
    end
  end

  logic [SUM_BITS-1:0] tree_sum;
  logic                tree_vld, tree_last, emit, ovf, full_neg;
  logic [OUT_BITS:0]   sum_ext, acc_ext, full;
  logic [OUT_BITS-1:0] sat_val, beat_val;
  logic [7:0]          cnt_inc;

  assign tree_sum  = node_q[LEVELS][0];
  assign tree_vld  = vld_q[LEVELS];
  assign tree_last = lst_q[LEVELS];
  assign emit      = (ACCUM == 0) || tree_last;

  // One extra bit of headroom makes the overflow test exact for both modes.
  assign sum_ext  = {{(OUT_BITS+1-SUM_BITS){(SIGNED != 0) && tree_sum[SUM_BITS-1]}}, tree_sum};
  assign acc_ext  = {(SIGNED != 0) && acc_q[OUT_BITS-1], acc_q};
  assign full     = acc_ext + sum_ext;
  assign full_neg = full[OUT_BITS];
  assign ovf      = (SIGNED != 0) ? (full[OUT_BITS] != full[OUT_BITS-1]) : full[OUT_BITS];

  assign sat_val  = (SIGNED == 0) ? {OUT_BITS{1'b1}} :
                    full_neg      ? {1'b1, {(OUT_BITS-1){1'b0}}} :
                                    {1'b0, {(OUT_BITS-1){1'b1}}};
  assign beat_val = (ovf && (SATURATE != 0)) ? sat_val : full[OUT_BITS-1:0];
  assign cnt_inc  = (cnt_q == 8'hFF) ? 8'hFF : cnt_q + 8'd1;

  // NOTE: every next-state variable takes its held value first, so no path
  // through this block can leave one unassigned and infer a latch.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_ovf_d    = out_ovf_q;
    out_count_d  = out_count_q;
    acc_d        = acc_q;
    ovf_sticky_d = ovf_sticky_q;
    cnt_d        = cnt_q;
    if (en) begin
      out_valid_d = 1'b0;
      if (tree_vld) begin
        if (emit) begin
          out_valid_d  = 1'b1;
          out_data_d   = beat_val;
          out_ovf_d    = ovf_sticky_q | ovf;
          out_count_d  = cnt_inc;
          acc_d        = '0;
          ovf_sticky_d = 1'b0;
          cnt_d        = 8'd0;
        end else begin
          acc_d        = beat_val;
          ovf_sticky_d = ovf_sticky_q | ovf;
          cnt_d        = cnt_inc;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_ovf_q    <= 1'b0;
      out_count_q  <= 8'd0;
      acc_q        <= '0;
      ovf_sticky_q <= 1'b0;
      cnt_q        <= 8'd0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_ovf_q    <= out_ovf_d;
      out_count_q  <= out_count_d;
      acc_q        <= acc_d;
      ovf_sticky_q <= ovf_sticky_d;
      cnt_q        <= cnt_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_overflow = out_ovf_q;
  assign out_count    = out_count_q;

endmodule

// File: tb/tb_adder_tree_stream.sv
// Directed bench for adder_tree_stream: four configurations share one input stream,
// each directed test checks the instance whose configuration it exercises.
module tb_adder_tree_stream;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b1;
  logic [63:0] in_data = '0;

  logic        in_ready_a, out_valid_a, out_overflow_a;
  logic [23:0] out_data_a;
  logic [7:0]  out_count_a;
  logic        in_ready_b, out_valid_b, out_overflow_b;
  logic [23:0] out_data_b;
  logic [7:0]  out_count_b;
  logic        in_ready_c, out_valid_c, out_overflow_c;
  logic [17:0] out_data_c;
  logic [7:0]  out_count_c;
  logic        in_ready_d, out_valid_d, out_overflow_d;
  logic [17:0] out_data_d;
  logic [7:0]  out_count_d;

  int n_checks = 0;
  int n_pass   = 0;
  int nvalid_b = 0;
  int got      = 0;
  int saw_stall = 0;
  int stall_bad = 0;

  // a: unsigned per-beat; b: signed accumulate; c/d: unsigned 18-bit accumulate, saturate / wrap
  adder_tree_stream #(.BITS(16), .NUM(4), .SIGNED(0), .ACCUM(0), .SATURATE(0), .OUT_BITS(24)) u_a (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
    .out_overflow(out_overflow_a), .out_count(out_count_a));
  adder_tree_stream #(.BITS(16), .NUM(4), .SIGNED(1), .ACCUM(1), .SATURATE(0), .OUT_BITS(24)) u_b (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
    .out_overflow(out_overflow_b), .out_count(out_count_b));
  adder_tree_stream #(.BITS(16), .NUM(4), .SIGNED(0), .ACCUM(1), .SATURATE(1), .OUT_BITS(18)) u_c (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready_c), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid_c), .out_ready(out_ready), .out_data(out_data_c),
    .out_overflow(out_overflow_c), .out_count(out_count_c));
  adder_tree_stream #(.BITS(16), .NUM(4), .SIGNED(0), .ACCUM(1), .SATURATE(0), .OUT_BITS(18)) u_d (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready_d), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid_d), .out_ready(out_ready), .out_data(out_data_d),
    .out_overflow(out_overflow_d), .out_count(out_count_d));

  always #5 clk = ~clk;

  always @(negedge clk) if (out_valid_b) nvalid_b++;

  task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    n_checks++;
    if (got_v === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got_v, exp_v);
  endtask

  task automatic sample(input int k, output logic v, output logic [23:0] d,
                        output logic o, output logic [7:0] c);
    case (k)
      0:       begin v = out_valid_a; d = out_data_a;         o = out_overflow_a; c = out_count_a; end
      1:       begin v = out_valid_b; d = out_data_b;         o = out_overflow_b; c = out_count_b; end
      2:       begin v = out_valid_c; d = {6'd0, out_data_c}; o = out_overflow_c; c = out_count_c; end
      default: begin v = out_valid_d; d = {6'd0, out_data_d}; o = out_overflow_d; c = out_count_d; end
    endcase
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the beat.
  task automatic send(input logic [15:0] l0, l1, l2, l3, input logic last);
    int waited = 0;
    in_valid = 1'b1;
    in_data  = {l3, l2, l1, l0};
    in_last  = last;
    @(negedge clk);
    while (!in_ready_a && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready_a) check("send_ready", in_ready_a, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic expect_result(input int k, input string tag, input logic [23:0] d_exp,
                               input logic o_exp, input logic [7:0] c_exp);
    logic v, o;
    logic [23:0] d;
    logic [7:0]  c;
    sample(k, v, d, o, c);
    for (int i = 0; i < 20 && !v; i++) begin
      @(negedge clk);
      sample(k, v, d, o, c);
    end
    check({tag, "_valid"}, v, 1);
    check({tag, "_data"},  d, d_exp);
    check({tag, "_ovf"},   o, o_exp);
    check({tag, "_count"}, c, c_exp);
  endtask

  task automatic apply_reset(input int cycles);
    resetn   = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (cycles) @(posedge clk);
    #1 resetn = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic v, o;
    logic [23:0] d;
    logic [7:0]  c;

    #1 resetn = 1'b1;
    @(negedge clk);
    check("rst_in_ready",  in_ready_a,     0);
    check("rst_out_valid", out_valid_a,    0);
    check("rst_out_data",  out_data_a,     0);
    check("rst_out_ovf",   out_overflow_a, 0);
    check("rst_out_count", out_count_a,    0);
    @(posedge clk);
    #1 resetn = 1'b0;
    @(negedge clk);
    check("idle_in_ready", in_ready_a, 1);
    @(posedge clk);
    #1;

    // Lanes {1,2,3,4}: result exactly three edges after acceptance.
    send(16'd1, 16'd2, 16'd3, 16'd4, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1;
    sample(0, v, d, o, c);
    check("lat_early_valid", v, 0);
    @(posedge clk);
    #1;
    sample(0, v, d, o, c);
    check("lat_valid", v, 1);
    check("sum_data",  d, 24'd10);
    check("sum_ovf",   o, 0);
    check("sum_count", c, 8'd1);

    // Signed lanes {-1,-2,3,32767} -> 32767.
    apply_reset(2);
    send(16'hFFFF, 16'hFFFE, 16'h0003, 16'h7FFF, 1'b1);
    expect_result(1, "signed", 24'h007FFF, 1'b0, 8'd1);
    @(posedge clk);
    #1;

    // Three beats of 4*0x7FFF accumulated into one result.
    apply_reset(2);
    nvalid_b = 0;
    send(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b0);
    send(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b0);
    send(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b1);
    expect_result(1, "accum", 24'h05FFF4, 1'b0, 8'd3);
    repeat (4) @(posedge clk);
    #1;
    check("accum_single_valid", nvalid_b, 1);

    // Two beats of 4*0xFFFF into 18 bits: saturate vs wrap.
    apply_reset(2);
    send(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0);
    send(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1);
    expect_result(2, "sat",  24'h03FFFF, 1'b1, 8'd2);
    expect_result(3, "wrap", 24'h03FFF8, 1'b1, 8'd2);
    @(posedge clk);
    #1;

    // Eight back-to-back beats with a 5-cycle output stall; beat k sums to 504k+101.
    apply_reset(2);
    got = 0;
    saw_stall = 0;
    stall_bad = 0;
    fork
      begin
        for (int k = 0; k < 8; k++)
          send(16'(k + 1), 16'(3 * k), 16'd100, 16'(500 * k), 1'b0);
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
      begin
        for (int cyc = 0; cyc < 100 && got < 8; cyc++) begin
          @(negedge clk);
          if (out_valid_a && !out_ready) begin
            saw_stall = 1;
            if (in_ready_a) stall_bad = 1;
          end
          if (out_valid_a && out_ready) begin
            check($sformatf("burst_%0d", got), out_data_a, 32'(504 * got + 101));
            got++;
          end
        end
      end
    join
    check("burst_count",      got,       8);
    check("burst_stalled",    saw_stall, 1);
    check("burst_ready_drop", stall_bad, 0);
    @(posedge clk);
    #1;

    // Reset mid-packet discards the partial sum.
    apply_reset(2);
    send(16'd1, 16'd1, 16'd1, 16'd1, 1'b0);
    send(16'd1, 16'd1, 16'd1, 16'd1, 1'b0);
    resetn = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", out_valid_b, 0);
    check("midrst_in_ready",  in_ready_b,  0);
    @(posedge clk);
    #1 resetn = 1'b0;
    send(16'd1, 16'd1, 16'd1, 16'd1, 1'b1);
    expect_result(1, "midrst", 24'd4, 1'b0, 8'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
